// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: the W-stage pipeline write always wins the single
// GRF write port; auxiliary long-latency results are queued in a small FIFO
// that drains on idle cycles and is squashed on write-after-write.
module grf_wb_arbiter #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_pipe_wen,
   input  logic [4:0]  i_pipe_wadd,
   input  logic [31:0] i_pipe_wdat,
   input  logic [31:0] i_pipe_pc,
   input  logic        i_aux_valid,
   output logic        o_aux_ready,
   input  logic [4:0]  i_aux_wadd,
   input  logic [31:0] i_aux_wdat,
   input  logic [31:0] i_aux_pc,
   output logic        o_grf_wen,
   output logic [4:0]  o_wadd,
   output logic [31:0] o_wdat,
   output logic [31:0] o_wpc,
   input  logic [4:0]  i_qadd1,
   input  logic [4:0]  i_qadd2,
   output logic        o_busy1,
   output logic        o_busy2
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic          r_live [DEPTH];
   logic [4:0]    r_wadd [DEPTH];
   logic [31:0]   r_wdat [DEPTH];
   logic [31:0]   r_pc   [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [AW:0]   r_count;

   logic w_pw;
   logic w_push;
   logic w_pop;
   logic w_nonempty;

   // Handshake and arbitration decisions; ready ignores any same-cycle pop.
   always_comb begin
      w_pw        = i_pipe_wen && (i_pipe_wadd != 5'd0);
      w_nonempty  = (r_count != '0);
      o_aux_ready = !rst && (r_count < FULL_CNT);
      w_push      = i_aux_valid && o_aux_ready && (i_aux_wadd != 5'd0);
      w_pop       = !rst && !w_pw && w_nonempty;
   end

   // Write-port mux: pipeline first, then a live head; squashed heads pop silently.
   always_comb begin
      o_grf_wen = 1'b0;
      o_wadd    = 5'd0;
      o_wdat    = 32'd0;
      o_wpc     = 32'd0;
      if (!rst) begin
         if (w_pw) begin
            o_grf_wen = 1'b1;
            o_wadd    = i_pipe_wadd;
            o_wdat    = i_pipe_wdat;
            o_wpc     = i_pipe_pc;
         end else if (w_nonempty && r_live[r_head]) begin
            o_grf_wen = 1'b1;
            o_wadd    = r_wadd[r_head];
            o_wdat    = r_wdat[r_head];
            o_wpc     = r_pc[r_head];
         end
      end
   end

   // Hazard query over stored slots only; popped slots have live cleared.
   always_comb begin
      o_busy1 = 1'b0;
      o_busy2 = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (r_live[i] && (i_qadd1 != 5'd0) && (r_wadd[i] == i_qadd1)) o_busy1 = 1'b1;
         if (r_live[i] && (i_qadd2 != 5'd0) && (r_wadd[i] == i_qadd2)) o_busy2 = 1'b1;
      end
      if (rst) begin
         o_busy1 = 1'b0;
         o_busy2 = 1'b0;
      end
   end

   // FIFO state: squash on pipeline WAW, retire head on pop, then store a push.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_live[i] <= 1'b0;
            r_wadd[i] <= 5'd0;
            r_wdat[i] <= 32'd0;
            r_pc[i]   <= 32'd0;
         end
      end else begin
         if (w_pw) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (r_wadd[i] == i_pipe_wadd) r_live[i] <= 1'b0;
            end
         end
         if (w_pop) begin
            r_live[r_head] <= 1'b0;
            r_head         <= r_head + 1'b1;
         end
         // Later assignment wins, so a same-cycle push is never squashed.
         if (w_push) begin
            r_live[r_tail] <= 1'b1;
            r_wadd[r_tail] <= i_aux_wadd;
            r_wdat[r_tail] <= i_aux_wdat;
            r_pc[r_tail]   <= i_aux_pc;
            r_tail         <= r_tail + 1'b1;
         end
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Self-checking bench for grf_wb_arbiter against a queue-based reference model.
module tb_grf_wb_arbiter;

   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [4:0]  wadd;
      logic [31:0] wdat;
      logic [31:0] pc;
      logic        live;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_wen;
   logic [4:0]  pipe_wadd;
   logic [31:0] pipe_wdat;
   logic [31:0] pipe_pc;
   logic        aux_valid;
   logic        aux_ready;
   logic [4:0]  aux_wadd;
   logic [31:0] aux_wdat;
   logic [31:0] aux_pc;
   logic        grf_wen;
   logic [4:0]  wadd;
   logic [31:0] wdat;
   logic [31:0] wpc;
   logic [4:0]  qadd1;
   logic [4:0]  qadd2;
   logic        busy1;
   logic        busy2;

   int checks = 0;
   int failures = 0;

   ent_t        mq[$];
   logic [72:0] exp_v;
   logic [72:0] obs_v;
   logic        obs_ready;
   logic        obs_wen;
   logic [4:0]  obs_wadd;
   logic [31:0] obs_wdat;
   logic [31:0] obs_wpc;
   logic        obs_busy1;
   logic        obs_busy2;
   logic [4:0]  log_addr[$];
   logic [31:0] log_dat[$];

   always #5 clk = ~clk;

   grf_wb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_pipe_wen  (pipe_wen),
      .i_pipe_wadd (pipe_wadd),
      .i_pipe_wdat (pipe_wdat),
      .i_pipe_pc   (pipe_pc),
      .i_aux_valid (aux_valid),
      .o_aux_ready (aux_ready),
      .i_aux_wadd  (aux_wadd),
      .i_aux_wdat  (aux_wdat),
      .i_aux_pc    (aux_pc),
      .o_grf_wen   (grf_wen),
      .o_wadd      (wadd),
      .o_wdat      (wdat),
      .o_wpc       (wpc),
      .i_qadd1     (qadd1),
      .i_qadd2     (qadd2),
      .o_busy1     (busy1),
      .o_busy2     (busy2)
   );

   // Expected outputs from the queue model: {ready, wen, wadd, wdat, wpc, busy1, busy2}.
   function automatic logic [72:0] model_out();
      logic r, wn, b1, b2, pw;
      logic [4:0] a;
      logic [31:0] d, p;
      r  = !rst && (mq.size() < int'(DEPTH));
      pw = pipe_wen && (pipe_wadd != 0);
      wn = 0; a = 0; d = 0; p = 0; b1 = 0; b2 = 0;
      if (!rst) begin
         if (pw) begin
            wn = 1; a = pipe_wadd; d = pipe_wdat; p = pipe_pc;
         end else if (mq.size() > 0 && mq[0].live) begin
            wn = 1; a = mq[0].wadd; d = mq[0].wdat; p = mq[0].pc;
         end
         foreach (mq[i]) begin
            if (mq[i].live && qadd1 != 0 && mq[i].wadd == qadd1) b1 = 1;
            if (mq[i].live && qadd2 != 0 && mq[i].wadd == qadd2) b2 = 1;
         end
      end
      return {r, wn, a, d, p, b1, b2};
   endfunction

   task automatic model_step();
      logic pw, rdy;
      if (rst) begin
         mq.delete();
      end else begin
         pw  = pipe_wen && (pipe_wadd != 0);
         rdy = mq.size() < int'(DEPTH);
         if (!pw && mq.size() > 0) void'(mq.pop_front());
         if (pw) foreach (mq[i]) if (mq[i].wadd == pipe_wadd) mq[i].live = 0;
         if (aux_valid && rdy && aux_wadd != 0)
            mq.push_back('{wadd: aux_wadd, wdat: aux_wdat, pc: aux_pc, live: 1'b1});
      end
   endtask

   // One clock: sample DUT on negedge, capture model expectation, advance model.
   task automatic tick();
      @(negedge clk);
      exp_v     = model_out();
      obs_ready = aux_ready; obs_wen = grf_wen; obs_wadd = wadd;
      obs_wdat  = wdat; obs_wpc = wpc; obs_busy1 = busy1; obs_busy2 = busy2;
      obs_v     = {aux_ready, grf_wen, wadd, wdat, wpc, busy1, busy2};
      if (grf_wen === 1'b1) begin
         log_addr.push_back(wadd);
         log_dat.push_back(wdat);
      end
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      pipe_wen = 0; pipe_wadd = 0; pipe_wdat = 0; pipe_pc = 0;
      aux_valid = 0; aux_wadd = 0; aux_wdat = 0; aux_pc = 0;
      qadd1 = 0; qadd2 = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1; pipe_wen = 1; pipe_wadd = 5'd3; pipe_wdat = 32'h55; aux_valid = 1; aux_wadd = 5'd4;
      tick();
      checks++;
      if (obs_ready !== 1'b0 || obs_wen !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold: ready=%b wen=%b required ready=0 wen=0", obs_ready, obs_wen);
      end
      tick();
      idle_inputs();
      rst = 0;
      tick();
      checks++;
      if (obs_ready !== 1'b1 || obs_wen !== 1'b0 || obs_busy1 !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: ready=%b wen=%b busy1=%b required 1 0 0",
                  obs_ready, obs_wen, obs_busy1);
      end
   endtask

   task automatic test_single_push();
      logic [72:0] want;
      idle_inputs();
      qadd1 = 5'd5;
      aux_valid = 1; aux_wadd = 5'd5; aux_wdat = 32'h1234; aux_pc = 32'h3000;
      tick();
      checks++;
      if (obs_wen !== 1'b0 || obs_busy1 !== 1'b0) begin
         failures++;
         $display("FAIL push_cycle: wen=%b busy1=%b required 0 0", obs_wen, obs_busy1);
      end
      aux_valid = 0;
      tick();
      want = {1'b1, 1'b1, 5'd5, 32'h1234, 32'h3000, 1'b1, 1'b0};
      checks++;
      if (obs_v !== want) begin
         failures++;
         $display("FAIL aux_write: got %h required %h", obs_v, want);
      end
      tick();
      checks++;
      if (obs_wen !== 1'b0 || obs_busy1 !== 1'b0) begin
         failures++;
         $display("FAIL after_drain: wen=%b busy1=%b required 0 0", obs_wen, obs_busy1);
      end
   endtask

   task automatic test_starve();
      int k = 0;
      logic [4:0] want_a[$];
      idle_inputs();
      log_addr.delete(); log_dat.delete();
      for (int c = 0; c < 14; c++) begin
         pipe_wen = (c < 6); pipe_wadd = 5'd8; pipe_wdat = 32'h800 + c; pipe_pc = 32'h100 + c;
         aux_valid = (k < 5); aux_wadd = 5'(9 + k); aux_wdat = 32'h900 + k; aux_pc = 32'h200 + k;
         tick();
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL starve_cycle%0d: got %h required %h", c, obs_v, exp_v);
         end
         if (c == 4 || c == 5) begin
            checks++;
            if (obs_ready !== 1'b0) begin
               failures++;
               $display("FAIL starve_ready%0d: got %b required 0", c, obs_ready);
            end
         end
         if (aux_valid && obs_ready) k++;
      end
      want_a = '{8, 8, 8, 8, 8, 8, 9, 10, 11, 12, 13};
      checks++;
      if (log_addr != want_a) begin
         failures++;
         $display("FAIL starve_order: got %p required %p", log_addr, want_a);
      end
   endtask

   task automatic test_squash();
      int n7 = 0;
      idle_inputs();
      log_addr.delete(); log_dat.delete();
      qadd1 = 5'd7;
      aux_valid = 1; aux_wadd = 5'd7; aux_wdat = 32'hAAAA; aux_pc = 32'h4000;
      tick();
      aux_valid = 0;
      pipe_wen = 1; pipe_wadd = 5'd7; pipe_wdat = 32'hBBBB; pipe_pc = 32'h4004;
      tick();
      checks++;
      if (obs_v !== exp_v || obs_busy1 !== 1'b1) begin
         failures++;
         $display("FAIL squash_pipe: got %h required %h", obs_v, exp_v);
      end
      pipe_wen = 0;
      tick();
      checks++;
      if (obs_wen !== 1'b0 || obs_busy1 !== 1'b0 || obs_v !== exp_v) begin
         failures++;
         $display("FAIL squash_pop: wen=%b busy1=%b required 0 0", obs_wen, obs_busy1);
      end
      tick();
      foreach (log_addr[i]) begin
         if (log_addr[i] == 5'd7) begin
            n7++;
            checks++;
            if (log_dat[i] !== 32'hBBBB) begin
               failures++;
               $display("FAIL squash_data: got %h required %h", log_dat[i], 32'hBBBB);
            end
         end
      end
      checks++;
      if (n7 != 1) begin
         failures++;
         $display("FAIL squash_count: got %0d writes to r7 required 1", n7);
      end
   endtask

   task automatic test_zero_reg();
      idle_inputs();
      aux_valid = 1; aux_wadd = 5'd0; aux_wdat = 32'hDEAD;
      pipe_wen = 1; pipe_wadd = 5'd0; pipe_wdat = 32'hBEEF;
      tick();
      checks++;
      if (obs_wen !== 1'b0 || obs_ready !== 1'b1 || obs_wadd !== 5'd0 || obs_wdat !== 32'd0) begin
         failures++;
         $display("FAIL zero_cycle: wen=%b ready=%b wadd=%0d required 0 1 0", obs_wen, obs_ready,
                  obs_wadd);
      end
      idle_inputs();
      tick();
      checks++;
      if (obs_wen !== 1'b0 || obs_v !== exp_v) begin
         failures++;
         $display("FAIL zero_after: got %h required %h", obs_v, exp_v);
      end
   endtask

   task automatic test_full_wrap();
      int k = 0;
      int c = 0;
      logic [31:0] aux_seen[$];
      idle_inputs();
      log_addr.delete(); log_dat.delete();
      // Fill with the pipe busy, then release it with aux_valid held.
      while (c < 200 && (k < 3 * int'(DEPTH) || mq.size() > 0 || c < 8)) begin
         if (c < 4) pipe_wen = 1;
         else if (c < 8) pipe_wen = 0;
         else pipe_wen = ($urandom_range(0, 3) == 0);
         pipe_wadd = 5'd31; pipe_wdat = 32'hF000 + c; pipe_pc = 32'h500 + c;
         aux_valid = (k < 3 * int'(DEPTH)) && (c < 8 || $urandom_range(0, 1) == 1);
         aux_wadd = 5'(1 + (k % 15)); aux_wdat = 32'h1000 + k; aux_pc = 32'h600 + k;
         tick();
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL wrap_cycle%0d: got %h required %h", c, obs_v, exp_v);
         end
         if (c == 4 || c == 5) begin
            checks++;
            if (obs_ready !== (c == 5) || obs_wen !== 1'b1 || obs_wadd !== 5'(c - 3)) begin
               failures++;
               $display("FAIL wrap_full%0d: ready=%b wen=%b wadd=%0d", c, obs_ready, obs_wen,
                        obs_wadd);
            end
         end
         if (aux_valid && obs_ready) k++;
         c++;
      end
      foreach (log_addr[i]) if (log_addr[i] != 5'd31) aux_seen.push_back(log_dat[i]);
      checks++;
      if (aux_seen.size() != 3 * int'(DEPTH)) begin
         failures++;
         $display("FAIL wrap_size: got %0d aux writes required %0d", aux_seen.size(), 3 * DEPTH);
      end
      foreach (aux_seen[i]) begin
         checks++;
         if (aux_seen[i] !== 32'h1000 + i) begin
            failures++;
            $display("FAIL wrap_order%0d: got %h required %h", i, aux_seen[i], 32'h1000 + i);
         end
      end
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      for (int c = 0; c < 3; c++) begin
         pipe_wen = 1; pipe_wadd = 5'd30; pipe_wdat = 32'h30;
         aux_valid = 1; aux_wadd = 5'(3 + c); aux_wdat = 32'h700 + c;
         tick();
      end
      idle_inputs();
      qadd1 = 5'd3; qadd2 = 5'd5;
      rst = 1;
      tick();
      rst = 0;
      log_addr.delete(); log_dat.delete();
      tick();
      checks++;
      if (obs_busy1 !== 1'b0 || obs_busy2 !== 1'b0 || obs_ready !== 1'b1) begin
         failures++;
         $display("FAIL midrst_state: busy1=%b busy2=%b ready=%b required 0 0 1",
                  obs_busy1, obs_busy2, obs_ready);
      end
      for (int c = 0; c < 6; c++) tick();
      checks++;
      if (log_addr.size() != 0) begin
         failures++;
         $display("FAIL midrst_writes: got %0d GRF writes required 0", log_addr.size());
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst       = ($urandom_range(0, 63) == 0);
         pipe_wen  = ($urandom_range(0, 2) == 0);
         pipe_wadd = 5'($urandom_range(0, 7));
         pipe_wdat = $urandom; pipe_pc = $urandom;
         aux_valid = ($urandom_range(0, 1) == 1);
         aux_wadd  = 5'($urandom_range(0, 7));
         aux_wdat  = $urandom; aux_pc = $urandom;
         qadd1     = 5'($urandom_range(0, 7));
         qadd2     = 5'($urandom_range(0, 7));
         tick();
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL random_cycle%0d: got %h required %h", c, obs_v, exp_v);
         end
      end
      rst = 0;
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_starve();
      test_squash();
      test_zero_reg();
      test_full_wrap();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
